// File: rtl/branch_operand_hazard_if.sv
// Bundle between the ID stage and the branch-operand hazard unit. It carries the
// ID-stage decode fields, the flush, the candidate forwarding values, and the
// returned mux select, forward value, stall and stall count.
interface branch_operand_hazard_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                  id_valid;
    logic                  id_is_branch;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [XLEN-1:0]       mem_alu_result;
    logic [XLEN-1:0]       wb_data;
    logic [1:0]            update;
    logic [XLEN-1:0]       forward;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    // Pipeline side: drives ID fields and data, consumes the decision.
    modport master (
        output id_valid, id_is_branch, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
        output flush, mem_alu_result, wb_data,
        input  update, forward, stall, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_is_branch, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
        input  flush, mem_alu_result, wb_data,
        output update, forward, stall, stall_count
    );
endinterface

// File: rtl/branch_operand_hazard_unit.sv
// ID-stage hazard unit for branch operands. It shadows the destination registers of
// in-flight instructions (EX/MEM/WB) and, for a branch in ID, picks one forwarding
// source or stalls. It also counts the cycles spent stalled.
module branch_operand_hazard_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_operand_hazard_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } slot_t;

    typedef enum logic [1:0] {NdNone, NdStall, NdFwdMem, NdFwdWb} need_e;

    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_count_q;
    need_e            need1, need2;
    logic             fwd1, fwd2;
    logic             stall_c;
    logic [1:0]       update_c;
    logic [XLEN-1:0]  forward_c;

    // The youngest in-flight writer of r decides. x0 never produces a hazard.
    function automatic need_e need_of(input logic [REG_ADDR_W-1:0] r,
                                      input slot_t ex, input slot_t mem, input slot_t wb);
        need_e n;
        n = NdNone;
        if (r != '0) begin
            if (ex.valid && ex.rd == r)        n = NdStall;
            else if (mem.valid && mem.rd == r) n = mem.is_load ? NdStall : NdFwdMem;
            else if (wb.valid && wb.rd == r)   n = NdFwdWb;
        end
        return n;
    endfunction

    // Per-operand need and combined forwarding/stall decision.
    always_comb begin
        need1     = NdNone;
        need2     = NdNone;
        stall_c   = 1'b0;
        update_c  = 2'b00;
        forward_c = '0;
        if (bus.id_valid && bus.id_is_branch) begin
            need1 = need_of(bus.id_rs1, ex_q, mem_q, wb_q);
            need2 = need_of(bus.id_rs2, ex_q, mem_q, wb_q);
        end
        fwd1 = (need1 == NdFwdMem) || (need1 == NdFwdWb);
        fwd2 = (need2 == NdFwdMem) || (need2 == NdFwdWb);
        // The mux forwards one operand only, so two forwards also stall.
        if (need1 == NdStall || need2 == NdStall || (fwd1 && fwd2)) begin
            stall_c = 1'b1;
        end else if (fwd1) begin
            update_c  = 2'b01;
            forward_c = (need1 == NdFwdMem) ? bus.mem_alu_result : bus.wb_data;
        end else if (fwd2) begin
            update_c  = 2'b10;
            forward_c = (need2 == NdFwdMem) ? bus.mem_alu_result : bus.wb_data;
        end
    end

    // Next EX slot: a bubble unless a valid, unstalled, unflushed writer of a nonzero rd.
    always_comb begin
        ex_d = '0;
        if (!stall_c && !bus.flush && bus.id_valid && bus.id_reg_write && bus.id_rd != '0) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = bus.id_rd;
            ex_d.is_load = bus.id_mem_read;
        end
    end

    // Advance the shadow slots and count stall cycles (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall_c) stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign bus.update      = update_c;
    assign bus.forward     = forward_c;
    assign bus.stall       = stall_c;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
// Directed bench for the branch-operand hazard unit with hand-computed expectations.
module tb_branch_operand_hazard_unit;
    localparam logic [31:0] AluVal = 32'h0000_00AA;
    localparam logic [31:0] WbVal  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    branch_operand_hazard_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) bus ();

    branch_operand_hazard_unit #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one ID-stage instruction.
    task automatic drive(input logic v, input logic br, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic fl);
        bus.id_valid     = v;
        bus.id_is_branch = br;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
        #2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd);
        drive(1, 0, 0, 0, rd, 1, 0, 0);
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
    endtask

    task automatic expect_out(input string tag, input logic st, input logic [1:0] up,
                              input logic [31:0] fw);
        check({tag, ".stall"}, 64'(bus.stall), 64'(st));
        check({tag, ".update"}, 64'(bus.update), 64'(up));
        check({tag, ".forward"}, 64'(bus.forward), 64'(fw));
    endtask

    initial begin
        bus.mem_alu_result = AluVal;
        bus.wb_data        = WbVal;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        expect_out("por", 0, 2'b00, 0);
        check("por.count", 64'(bus.stall_count), 0);
        rst_n = 1'b1;
        cyc();

        // Reset mid-stall.
        alu(5);
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        check("rst.pre_stall", 64'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        expect_out("rst.mid", 0, 2'b00, 0);
        check("rst.count", 64'(bus.stall_count), 0);
        rst_n = 1'b1;
        #1;
        expect_out("rst.after", 0, 2'b00, 0);
        cyc();
        idle(3);

        // ALU result feeding a branch: one stall, then forward from MEM on rs1.
        alu(5);
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        expect_out("alu.c0", 1, 2'b00, 0);
        cyc();
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        expect_out("alu.c1", 0, 2'b01, AluVal);
        cyc();
        idle(3);

        // Load feeding a branch on rs2: two stalls, then WB forward, then nothing.
        drive(1, 0, 0, 0, 6, 1, 1, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 6, 0, 0, 0, 0);
            case (i)
                0, 1: expect_out("load.stall", 1, 2'b00, 0);
                2: expect_out("load.fwd", 0, 2'b10, WbVal);
                default: expect_out("load.done", 0, 2'b00, 0);
            endcase
            cyc();
        end
        idle(3);

        // x7 in MEM, x8 in WB: one stall, then x7 forwarded from WB.
        alu(8);
        alu(7);
        idle(1);
        drive(1, 1, 7, 8, 0, 0, 0, 0);
        expect_out("dbl.c0", 1, 2'b00, 0);
        cyc();
        drive(1, 1, 7, 8, 0, 0, 0, 0);
        expect_out("dbl.c1", 0, 2'b01, WbVal);
        cyc();
        idle(3);

        // rs1 == rs2 == x9 in EX: three stalls, then clear.
        alu(9);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 9, 9, 0, 0, 0, 0);
            if (i < 3) expect_out("same.stall", 1, 2'b00, 0);
            else       expect_out("same.done", 0, 2'b00, 0);
            cyc();
        end
        check("count.mid", 64'(bus.stall_count), 7);

        // Writes to x0 are never tracked.
        alu(0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        expect_out("x0", 0, 2'b00, 0);
        cyc();
        idle(3);

        // Non-branch and invalid ID never stall even with a live hazard.
        alu(11);
        drive(1, 0, 11, 11, 0, 0, 0, 0);
        expect_out("nonbr", 0, 2'b00, 0);
        drive(0, 1, 11, 11, 0, 0, 0, 0);
        expect_out("invalid", 0, 2'b00, 0);
        cyc();
        idle(3);

        // Flushed writer leaves no hazard.
        drive(1, 0, 0, 0, 10, 1, 0, 1);
        cyc();
        drive(1, 1, 10, 0, 0, 0, 0, 0);
        expect_out("flush", 0, 2'b00, 0);
        cyc();
        idle(3);

        check("count.final", 64'(bus.stall_count), 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_operand_hazard_unit.md
Name: branch_operand_hazard_unit

Overview:
- ID-stage control block for the RV32I pipeline. It sits directly upstream of the branch-operand forwarding mux and drives that mux's 2-bit select (`update`) and 32-bit `forward` value.
- It tracks destination registers of in-flight instructions in its own EX/MEM/WB shadow slots. When a branch in ID reads a register still in flight, it selects a forwarding source or stalls ID.
- It also counts the total branch stall cycles.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_is_branch  in  1  ID instruction is a conditional branch (uses rs1/rs2 in ID).
- id_rs1  in  REG_ADDR_W  branch source 1.
- id_rs2  in  REG_ADDR_W  branch source 2.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  taken-branch/jump flush; squashes the instruction entering EX.
- mem_alu_result  in  XLEN  ALU result held in the MEM stage.
- wb_data  in  XLEN  final writeback value in the WB stage.
- update  out  2  forwarding mux select: 00 none, 01 forward to rs1, 10 forward to rs2; 11 is never driven.
- forward  out  XLEN  forwarded value.
- stall  out  1  freeze PC/IF/ID and inject a bubble into EX.
- stall_count  out  CNT_W  cumulative stall cycles.

Behaviour:
- State: three slots ex_s, mem_s, wb_s, each holding {valid, rd, is_load}.
- Reset (async, rst_n=0): all slot valid bits are 0 and stall_count=0. Outputs then settle to update=00, forward=0, stall=0. Reset mid-stall abandons the stall immediately.
- Slot advance (every posedge): wb_s<=mem_s and mem_s<=ex_s.
  - ex_s<=bubble if stall | flush | !id_valid | !id_reg_write | id_rd==0.
  - Otherwise ex_s<={1, id_rd, id_mem_read}.
- Per-operand need(r), combinational, evaluated only when id_valid & id_is_branch & r!=0. Youngest match wins:
  - ex_s.valid & ex_s.rd==r -> STALL.
  - else mem_s match, !is_load -> FWD_MEM.
  - else mem_s match, is_load -> STALL.
  - else wb_s match -> FWD_WB.
  - else NONE.
- Combined decision:
  - Either operand STALL -> stall=1, update=00.
  - Both operands FWD_* (including rs1==rs2 in flight) -> stall=1, update=00, because the mux forwards only one operand.
  - Exactly one FWD -> stall=0; update=01 for rs1 or 10 for rs2; forward=mem_alu_result or wb_data accordingly.
  - Otherwise stall=0, update=00.
- forward=0 whenever update=00.
- Non-branch in ID, or id_valid=0: update=00, stall=0. Slot tracking still runs.
- Outputs are combinational from slots plus ID inputs, with zero latency; the mux consumes them in the same cycle.
- Stall is self-resolving. Because stall inserts bubbles, a hazard ages EX->MEM->WB->retired, so the maximum consecutive stall is 3 cycles (both operands dependent, or rs1==rs2, on an EX-stage instruction).
- The register file is write-then-read. After the WB slot retires, no forward is needed.
- flush and stall simultaneous: ex_s<=bubble; stall still reported for the cycle. flush does not clear mem_s/wb_s.
- stall_count increments by 1 on each posedge where stall=1, and wraps modulo 2^CNT_W.
- x0 is never tracked and never forwarded.

Test Plan:
- Reset: assert rst_n=0 mid-stall (ex_s holds rd=5, branch on x5) -> update=00, stall=0, stall_count=0 immediately. After release, ex_s is empty.
- ALU-to-branch: issue `add x5`, then a branch on rs1=x5 -> stall=1 for exactly 1 cycle. Next cycle update=01 and forward=mem_alu_result (e.g. 0x0000_00AA).
- Load-to-branch: issue `lw x6`, then a branch on rs2=x6 -> stall for 2 cycles, then update=10 with forward=wb_data (0xDEAD_BEEF), then 00.
- Double dependency: `add x7` in MEM and `add x8` in WB, branch rs1=x7, rs2=x8 -> stall=1. After one bubble, x7 is in WB and x8 retired -> update=01, forward=wb_data.
- rs1==rs2==x9 with x9 in EX -> stall for 3 cycles, then update=00. A branch with rs1=x0 while x0 is "written" -> no stall.
- flush on the cycle an `add x10` enters EX -> a later branch on x10 sees no hazard. stall_count equals the total stall cycles across all scenarios.
